// File: rtl/pmem_loader.sv
// Program-memory loader: turns a framed byte stream (sync, count, big-endian words)
// into one-cycle pmem write strobes while holding the core off the bus.
module pmem_loader #(
    parameter int           PMEM_ADDR_WIDTH = 12,
    parameter int           PMEM_WORD_WIDTH = 16,
    parameter int           PMEM_NUM_WORDS  = 2048,
    parameter int           PC_INCREMENT    = 2,
    parameter int           START_ADDR      = 0,
    parameter logic [7:0]   SYNC_BYTE       = 8'hA5
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [7:0]                  in_byte,
    input  logic                        in_byte_valid,
    output logic                        out_byte_ready,
    output logic                        out_pmem_write,
    output logic [PMEM_ADDR_WIDTH-1:0]  out_pmem_addr,
    output logic [PMEM_WORD_WIDTH-1:0]  out_pmem_word,
    output logic                        out_cpu_hold,
    output logic                        out_done,
    output logic                        out_error
);

    // state   | meaning
    // IDLE    | hunting for the sync byte, other bytes dropped
    // CNT_HI  | waiting for word count, high byte
    // CNT_LO  | waiting for word count, low byte
    // DATA_HI | waiting for high byte of the next word
    // DATA_LO | waiting for low byte of the next word
    // WRITE   | single-cycle pmem write (suppressed past capacity)
    // DONE    | end-of-frame pulse, releases the core
    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [PMEM_ADDR_WIDTH-1:0] ADDR_START = PMEM_ADDR_WIDTH'(START_ADDR);
    localparam logic [PMEM_ADDR_WIDTH-1:0] ADDR_STEP  = PMEM_ADDR_WIDTH'(PC_INCREMENT);
    localparam logic [16:0]                NUM_WORDS  = 17'(PMEM_NUM_WORDS);

    state_t                      state_q, state_d;
    logic [15:0]                 remaining_q, remaining_d;
    logic [15:0]                 index_q, index_d;
    logic [PMEM_ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [15:0]                 word_q, word_d;
    logic                        hold_q, hold_d;
    logic                        error_q, error_d;

    logic                        byte_ready;
    logic                        accept;
    logic                        in_range;
    logic                        pmem_write;
    logic                        done_pulse;

    assign byte_ready = (state_q != S_WRITE) && (state_q != S_DONE);
    assign accept     = in_byte_valid && byte_ready;
    assign in_range   = {1'b0, index_q} < NUM_WORDS;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        index_d     = index_q;
        addr_d      = addr_q;
        word_d      = word_q;
        hold_d      = hold_q;
        error_d     = error_q;
        pmem_write  = 1'b0;
        done_pulse  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept && (in_byte == SYNC_BYTE)) begin
                    state_d = S_CNT_HI;
                    error_d = 1'b0;
                    hold_d  = 1'b1;
                    addr_d  = ADDR_START;
                    index_d = '0;
                end
            end
            S_CNT_HI: begin
                if (accept) begin
                    remaining_d = {in_byte, remaining_q[7:0]};
                    state_d     = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (accept) begin
                    remaining_d = {remaining_q[15:8], in_byte};
                    state_d     = (remaining_d == '0) ? S_DONE : S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                if (accept) begin
                    word_d  = {in_byte, word_q[7:0]};
                    state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (accept) begin
                    word_d  = {word_q[15:8], in_byte};
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // Overflow words are still consumed so the frame stays aligned.
                pmem_write  = in_range;
                error_d     = error_q | ~in_range;
                index_d     = index_q + 16'd1;
                addr_d      = addr_q + ADDR_STEP;
                remaining_d = remaining_q - 16'd1;
                state_d     = (remaining_q == 16'd1) ? S_DONE : S_DATA_HI;
            end
            S_DONE: begin
                done_pulse = 1'b1;
                hold_d     = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            index_q     <= '0;
            addr_q      <= ADDR_START;
            word_q      <= '0;
            hold_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            index_q     <= index_d;
            addr_q      <= addr_d;
            word_q      <= word_d;
            hold_q      <= hold_d;
            error_q     <= error_d;
        end
    end

    assign out_byte_ready = byte_ready;
    assign out_pmem_write = pmem_write;
    assign out_pmem_addr  = addr_q;
    assign out_pmem_word  = PMEM_WORD_WIDTH'(word_q);
    assign out_cpu_hold   = hold_q;
    assign out_done       = done_pulse;
    assign out_error      = error_q;

endmodule

// File: tb/tb_pmem_loader.sv
// Bench for pmem_loader: a full-size instance (a) and a two-word instance (b)
// share clock/reset; pmem writes are matched against a per-instance expected queue.
module tb_pmem_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        valid_a = 1'b0;
    logic        valid_b = 1'b0;
    logic        sel = 1'b0;

    logic        rdy_a, wr_a, hold_a, done_a, err_a;
    logic [11:0] addr_a;
    logic [15:0] word_a;
    logic        rdy_b, wr_b, hold_b, done_b, err_b;
    logic [11:0] addr_b;
    logic [15:0] word_b;

    int          n_chk = 0;
    int          n_err = 0;
    int          dones_a = 0;
    int          dones_b = 0;
    logic [27:0] exp_a[$];
    logic [27:0] exp_b[$];

    always #5 clock = ~clock;

    pmem_loader dut_a (
        .clock(clock), .reset(reset), .in_byte(in_byte), .in_byte_valid(valid_a),
        .out_byte_ready(rdy_a), .out_pmem_write(wr_a), .out_pmem_addr(addr_a),
        .out_pmem_word(word_a), .out_cpu_hold(hold_a), .out_done(done_a), .out_error(err_a)
    );

    pmem_loader #(.PMEM_NUM_WORDS(2)) dut_b (
        .clock(clock), .reset(reset), .in_byte(in_byte), .in_byte_valid(valid_b),
        .out_byte_ready(rdy_b), .out_pmem_write(wr_b), .out_pmem_addr(addr_b),
        .out_pmem_word(word_b), .out_cpu_hold(hold_b), .out_done(done_b), .out_error(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Unreachable address 0xFFF marks a write nobody expected.
    always @(negedge clock) begin
        if (reset) begin
            if (wr_a) begin
                chk("a_wr", {addr_a, word_a}, (exp_a.size() > 0) ? exp_a.pop_front() : 28'hFFFFFFF);
                chk("a_ready_in_write", rdy_a, 0);
            end
            if (wr_b) begin
                chk("b_wr", {addr_b, word_b}, (exp_b.size() > 0) ? exp_b.pop_front() : 28'hFFFFFFF);
                chk("b_ready_in_write", rdy_b, 0);
            end
            if (done_a) dones_a++;
            if (done_b) dones_b++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clock);
        @(negedge clock);
        in_byte = b;
        if (sel) valid_b = 1'b1; else valid_a = 1'b1;
        n = 0;
        while (!(sel ? rdy_b : rdy_a) && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) chk("ready_timeout", n, 0);
        @(posedge clock);
        #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    initial begin
        // Reset held with valid asserted: nothing may be consumed.
        valid_a = 1'b1;
        valid_b = 1'b1;
        in_byte = 8'hA5;
        repeat (3) begin
            @(negedge clock);
            chk("rst_ready", rdy_a, 1);
            chk("rst_hold", hold_a, 0);
            chk("rst_write", wr_a, 0);
        end
        chk("rst_addr", addr_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_error", err_b, 0);
        valid_a = 1'b0;
        valid_b = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("post_rst_hold", hold_a, 0);

        // Garbage before sync, then two words.
        sel = 1'b0;
        send_byte(8'h00, 0);
        send_byte(8'h12, 0);
        @(negedge clock);
        chk("idle_discard_hold", hold_a, 0);
        send_byte(8'hA5, 0);
        @(negedge clock);
        chk("sync_hold", hold_a, 1);
        exp_a.push_back({12'h000, 16'h1234});
        exp_a.push_back({12'h002, 16'hABCD});
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        @(negedge clock);
        chk("t2_write_cycle", wr_a, 1);
        chk("t2_write_ready", rdy_a, 0);
        @(negedge clock);
        chk("t2_done", done_a, 1);
        chk("t2_done_hold", hold_a, 1);
        chk("t2_done_ready", rdy_a, 0);
        @(negedge clock);
        chk("t2_done_end", done_a, 0);
        chk("t2_hold_fall", hold_a, 0);
        chk("t2_ready_back", rdy_a, 1);

        // Zero-length frame.
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        @(negedge clock);
        chk("t3_done", done_a, 1);
        chk("t3_nowrite", wr_a, 0);
        chk("t3_error", err_a, 0);
        @(negedge clock);
        chk("t3_done_end", done_a, 0);
        chk("t3_hold", hold_a, 0);

        // Three words with valid toggling; sync value inside data is plain data.
        exp_a.push_back({12'h000, 16'h0102});
        exp_a.push_back({12'h002, 16'hA5A5});
        exp_a.push_back({12'h004, 16'hFFFF});
        send_byte(8'hA5, 1);
        send_byte(8'h00, 1);
        send_byte(8'h03, 1);
        send_byte(8'h01, 1);
        send_byte(8'h02, 1);
        send_byte(8'hA5, 1);
        send_byte(8'hA5, 1);
        send_byte(8'hFF, 1);
        send_byte(8'hFF, 1);
        repeat (4) @(negedge clock);
        chk("t4_hold", hold_a, 0);
        chk("t4_error", err_a, 0);
        chk("t4_pending", exp_a.size(), 0);

        // Capacity overflow on the two-word instance.
        sel = 1'b1;
        exp_b.push_back({12'h000, 16'h1111});
        exp_b.push_back({12'h002, 16'h2222});
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_byte(8'h11, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h33, 0);
        @(negedge clock);
        chk("t5_overflow_nowrite", wr_b, 0);
        @(negedge clock);
        chk("t5_error_set", err_b, 1);
        chk("t5_done", done_b, 1);
        repeat (4) @(negedge clock);
        chk("t5_error_sticky", err_b, 1);
        send_byte(8'hA5, 0);
        @(negedge clock);
        chk("t5_error_clear", err_b, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        repeat (3) @(negedge clock);
        chk("t5_pending", exp_b.size(), 0);

        // Reset after the high byte of word 2.
        sel = 1'b0;
        exp_a.push_back({12'h000, 16'h1122});
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("t6_rst_hold", hold_a, 0);
        chk("t6_rst_ready", rdy_a, 1);
        chk("t6_rst_addr", addr_a, 0);
        @(negedge clock);
        reset = 1'b1;
        exp_a.push_back({12'h000, 16'h5566});
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        repeat (4) @(negedge clock);
        chk("t6_pending", exp_a.size(), 0);
        chk("a_done_count", dones_a, 4);
        chk("b_done_count", dones_b, 2);
        chk("t6_hold", hold_a, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
